// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: frame-format encodings, receiver
// states and the tagged FIFO entry layout.
package uart_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ENTRY_W = DATA_W + 3;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_t;

    typedef enum logic [1:0] {
        DB_5 = 2'b00,
        DB_6 = 2'b01,
        DB_7 = 2'b10,
        DB_8 = 2'b11
    } data_bits_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_t;

    typedef struct packed {
        logic              brk;
        logic              ferr;
        logic              perr;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

    // Index of the final data bit for a given data-bit encoding (5..8 bits).
    function automatic logic [2:0] last_bit_idx(input data_bits_t db);
        return 3'(4) + 3'(db);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus between the receive FIFO and the register front-end.
interface uart_rx_fifo_if #(
    parameter int unsigned LVL_W = 5
);
    logic             rd_en;
    logic             ovr_clr;
    logic [7:0]       rd_data;
    logic             rd_perr;
    logic             rd_ferr;
    logic             rd_brk;
    logic             empty;
    logic             full;
    logic [LVL_W-1:0] level;
    logic             overrun;

    modport master (
        output rd_en, ovr_clr,
        input  rd_data, rd_perr, rd_ferr, rd_brk, empty, full, level, overrun
    );

    modport slave (
        input  rd_en, ovr_clr,
        output rd_data, rd_perr, rd_ferr, rd_brk, empty, full, level, overrun
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers; holds the
// last popped word on the output while empty and flags pushes lost to a full FIFO.
module sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !pop;
    assign rdata   = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                last_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority voting and runtime frame format,
// feeding an error-tagged FWFT receive FIFO with sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVS        = 16,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic           uart_clk,
    input  logic           rst_n,
    input  logic           sample_tick,
    input  logic           rxd,
    input  logic [1:0]     cfg_data_bits,
    input  logic [1:0]     cfg_parity,
    input  logic           cfg_stop2,
    uart_rx_fifo_if.slave  rd_bus
);
    localparam int unsigned CW = $clog2(OVS);

    logic [1:0]  sync_q;
    logic        rxd_s;
    rx_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  data_q;
    logic        perr_q;
    logic        ferr_q;
    logic        par_q;
    logic        s0_q;
    logic        s1_q;
    logic        armed_q;
    data_bits_t  db_q;
    parity_t     par_cfg_q;
    logic        stop2_q;
    logic        push_q;
    rx_entry_t   entry_q;
    rx_entry_t   entry_c;
    rx_entry_t   head;
    logic        vote;
    logic        at_vote;
    logic        at_end;
    logic        par_en;
    logic        exp_par;
    logic        overrun_q;
    logic        fifo_drop;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    assign rxd_s   = sync_q[1];
    assign at_vote = (cnt == CW'(OVS / 2 + 1));
    assign at_end  = (cnt == CW'(OVS - 1));
    assign vote    = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);
    assign par_en  = (par_cfg_q == PAR_EVEN) || (par_cfg_q == PAR_ODD);
    assign exp_par = (^data_q) ^ (par_cfg_q == PAR_ODD);

    // Entry as it stands at the final stop-bit vote; vote is that stop sample.
    always_comb begin
        entry_c      = '0;
        entry_c.data = data_q;
        entry_c.perr = perr_q;
        entry_c.ferr = ferr_q | ~vote;
        entry_c.brk  = (data_q == 8'h00) && !par_q && !vote;
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    // Receiver FSM; everything advances only on sample ticks.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            par_q     <= 1'b0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            armed_q   <= 1'b0;
            db_q      <= DB_8;
            par_cfg_q <= PAR_NONE;
            stop2_q   <= 1'b0;
            push_q    <= 1'b0;
            entry_q   <= '0;
        end else begin
            push_q <= 1'b0;
            if (sample_tick) begin
                if (state != IDLE) begin
                    cnt <= at_end ? '0 : cnt + CW'(1);
                    if (cnt == CW'(OVS / 2 - 1)) s0_q <= rxd_s;
                    if (cnt == CW'(OVS / 2))     s1_q <= rxd_s;
                end
                case (state)
                    IDLE: begin
                        if (!rxd_s && armed_q) begin
                            state     <= START;
                            cnt       <= '0;
                            bit_idx   <= '0;
                            data_q    <= '0;
                            perr_q    <= 1'b0;
                            ferr_q    <= 1'b0;
                            par_q     <= 1'b0;
                            db_q      <= data_bits_t'(cfg_data_bits);
                            par_cfg_q <= parity_t'(cfg_parity);
                            stop2_q   <= cfg_stop2;
                        end else if (rxd_s) begin
                            armed_q <= 1'b1;
                        end
                    end
                    START: begin
                        if (at_vote && vote) begin
                            state   <= IDLE;
                            armed_q <= 1'b0;
                        end else if (at_end) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (at_vote) data_q[bit_idx] <= vote;
                        if (at_end) begin
                            if (bit_idx == last_bit_idx(db_q)) begin
                                state <= par_en ? PARITY : STOP1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (at_vote) begin
                            par_q  <= vote;
                            perr_q <= (vote != exp_par);
                        end
                        if (at_end) state <= STOP1;
                    end
                    STOP1: begin
                        if (at_vote) begin
                            if (stop2_q) begin
                                ferr_q <= ~vote;
                            end else begin
                                entry_q <= entry_c;
                                push_q  <= 1'b1;
                                state   <= IDLE;
                                armed_q <= 1'b0;
                            end
                        end
                        if (at_end && stop2_q) state <= STOP2;
                    end
                    STOP2: begin
                        if (at_vote) begin
                            entry_q <= entry_c;
                            push_q  <= 1'b1;
                            state   <= IDLE;
                            armed_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (uart_clk),
        .rst_n (rst_n),
        .push  (push_q),
        .wdata (entry_q),
        .pop   (rd_bus.rd_en),
        .rdata (head),
        .empty (rd_bus.empty),
        .full  (rd_bus.full),
        .level (fifo_level),
        .drop  (fifo_drop)
    );

    // Set wins over clear.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (fifo_drop) begin
            overrun_q <= 1'b1;
        end else if (rd_bus.ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign rd_bus.rd_data = head.data;
    assign rd_bus.rd_perr = head.perr;
    assign rd_bus.rd_ferr = head.ferr;
    assign rd_bus.rd_brk  = head.brk;
    assign rd_bus.level   = LVL_W'(fifo_level);
    assign rd_bus.overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame timing, parity, glitch/framing,
// break, full/overrun and mid-frame reset, with hand-computed expectations.
module tb_uart_rx_fifo;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned OVS_P    = 16;
    localparam int unsigned LW       = 3;
    localparam int unsigned BIT_CLKS = 2 * OVS_P;

    logic       uart_clk      = 1'b0;
    logic       rst_n         = 1'b0;
    logic       sample_tick   = 1'b0;
    logic       rxd           = 1'b1;
    logic [1:0] cfg_data_bits = 2'b11;
    logic [1:0] cfg_parity    = 2'b00;
    logic       cfg_stop2     = 1'b0;
    int         total         = 0;
    int         bad           = 0;
    bit         hit;
    logic [7:0] frm;

    uart_rx_fifo_if #(.LVL_W(LW)) bus ();

    uart_rx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .OVS        (OVS_P),
        .LVL_W      (LW)
    ) dut (
        .uart_clk      (uart_clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .rxd           (rxd),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .rd_bus        (bus.slave)
    );

    always #5 uart_clk = ~uart_clk;

    // One tick every other clock.
    initial forever begin
        @(negedge uart_clk);
        sample_tick = ~sample_tick;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(negedge uart_clk);
    endtask

    // par: 0 none, 1 even, 2 odd; flip inverts the parity bit sent.
    task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                              input bit flip, input logic st1, input logic st2, input bit two);
        logic p;
        p = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(d[i]);
            p ^= d[i];
        end
        if (par != 0) begin
            if (par == 2) p = ~p;
            if (flip) p = ~p;
            send_bit(p);
        end
        send_bit(st1);
        if (two) send_bit(st2);
        rxd = 1'b1;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic perr,
                           input logic ferr, input logic brk);
        chk({tag, "_data"}, 32'(bus.rd_data), 32'(d));
        chk({tag, "_perr"}, 32'(bus.rd_perr), 32'(perr));
        chk({tag, "_ferr"}, 32'(bus.rd_ferr), 32'(ferr));
        chk({tag, "_brk"},  32'(bus.rd_brk),  32'(brk));
        bus.rd_en = 1'b1;
        @(negedge uart_clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rd_en   = 1'b0;
        bus.ovr_clr = 1'b0;
        repeat (3) @(negedge uart_clk);
        chk("rst_data",    32'(bus.rd_data), 32'h0);
        chk("rst_flags",   32'({bus.rd_perr, bus.rd_ferr, bus.rd_brk}), 32'h0);
        chk("rst_empty",   32'(bus.empty),   32'h1);
        chk("rst_full",    32'(bus.full),    32'h0);
        chk("rst_level",   32'(bus.level),   32'h0);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(negedge uart_clk);

        // 8N1 0xA5 with push-latency probe, then 0x3C back-to-back
        frm = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(frm[i]);
        chk("push_early", 32'(bus.level), 32'h0);
        send_bit(1'b1);
        chk("push_lat", 32'(bus.level), 32'h1);
        send_frame(8'h3C, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("b2b_level", 32'(bus.level), 32'h2);
        pop_chk("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        pop_chk("3c", 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("b2b_empty", 32'(bus.empty), 32'h1);

        // 7E1 and 7O1, good then flipped parity
        cfg_data_bits = 2'b10;
        cfg_parity    = 2'b01;
        send_frame(8'h41, 7, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h41, 7, 1, 1'b1, 1'b1, 1'b1, 1'b0);
        pop_chk("even_ok",  8'h41, 1'b0, 1'b0, 1'b0);
        pop_chk("even_bad", 8'h41, 1'b1, 1'b0, 1'b0);
        cfg_parity = 2'b10;
        send_frame(8'h41, 7, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h41, 7, 2, 1'b1, 1'b1, 1'b1, 1'b0);
        pop_chk("odd_ok",  8'h41, 1'b0, 1'b0, 1'b0);
        pop_chk("odd_bad", 8'h41, 1'b1, 1'b0, 1'b0);

        // 3-tick glitch, then a clean frame proves the receiver is idle again
        cfg_data_bits = 2'b11;
        cfg_parity    = 2'b00;
        rxd = 1'b0;
        repeat (6) @(negedge uart_clk);
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge uart_clk);
        chk("glitch_level", 32'(bus.level), 32'h0);
        send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        pop_chk("post_glitch", 8'h5A, 1'b0, 1'b0, 1'b0);

        // 8N2 with second stop bit low
        cfg_stop2 = 1'b1;
        send_frame(8'h96, 8, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge uart_clk);
        chk("stop2_level", 32'(bus.level), 32'h1);
        pop_chk("stop2", 8'h96, 1'b0, 1'b1, 1'b0);
        cfg_stop2 = 1'b0;

        // Break: 12 bit-times low yields exactly one entry
        rxd = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge uart_clk);
        chk("brk_hold", 32'(bus.level), 32'h1);
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge uart_clk);
        chk("brk_rel", 32'(bus.level), 32'h1);
        pop_chk("brk", 8'h00, 1'b0, 1'b1, 1'b1);

        // Fill a depth-4 FIFO with five frames
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovr_full",  32'(bus.full),    32'h1);
        chk("ovr_level", 32'(bus.level),   32'h4);
        chk("ovr_set",   32'(bus.overrun), 32'h1);
        bus.ovr_clr = 1'b1;
        @(negedge uart_clk);
        bus.ovr_clr = 1'b0;
        chk("ovr_clr", 32'(bus.overrun), 32'h0);

        // Sixth push coincides with a pop while full
        hit = 1'b0;
        fork
            send_frame(8'h06, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
            begin
                for (int i = 0; i < int'(12 * BIT_CLKS); i++) begin
                    @(negedge uart_clk);
                    if (dut.push_q) begin
                        hit = 1'b1;
                        break;
                    end
                end
                if (hit) begin
                    bus.rd_en = 1'b1;
                    @(negedge uart_clk);
                    bus.rd_en = 1'b0;
                end
            end
        join
        chk("push6_seen",  32'(hit),         32'h1);
        chk("push6_level", 32'(bus.level),   32'h4);
        chk("push6_full",  32'(bus.full),    32'h1);
        chk("push6_novr",  32'(bus.overrun), 32'h0);
        pop_chk("q2", 8'h02, 1'b0, 1'b0, 1'b0);
        pop_chk("q3", 8'h03, 1'b0, 1'b0, 1'b0);
        pop_chk("q4", 8'h04, 1'b0, 1'b0, 1'b0);
        pop_chk("q6", 8'h06, 1'b0, 1'b0, 1'b0);
        chk("drain_empty", 32'(bus.empty), 32'h1);

        // Reset during data bit 3 of a 0x55 frame, with one entry queued
        send_frame(8'h77, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_pre", 32'(bus.level), 32'h1);
        frm = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(frm[i]);
        rxd = frm[3];
        repeat (BIT_CLKS / 2) @(negedge uart_clk);
        rst_n = 1'b0;
        repeat (3) @(negedge uart_clk);
        chk("mrst_data",  32'(bus.rd_data), 32'h0);
        chk("mrst_flags", 32'({bus.rd_perr, bus.rd_ferr, bus.rd_brk}), 32'h0);
        chk("mrst_empty", 32'(bus.empty),   32'h1);
        chk("mrst_level", 32'(bus.level),   32'h0);
        rxd   = 1'b1;
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge uart_clk);
        chk("mrst_nopush", 32'(bus.level), 32'h0);
        send_frame(8'h55, 8, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_level", 32'(bus.level), 32'h1);
        pop_chk("post_rst", 8'h55, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
